charattr_row_fetch: RTL

Fills the 80x32 character/attribute row buffer ahead of each text row. On a start pulse it reads COLUMNS consecutive 32-bit words from video memory through the memory arbiter's pipelined read port and writes them in order into the row buffer's write port (address, enable, data). It sits directly upstream of the row buffer and is started by the video timing block once per text row.

---
 rtl/charattr_row_fetch.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/charattr_row_fetch.sv
// Row prefetcher: streams COLUMNS words from video memory through the arbiter's
// pipelined read port into the character/attribute row buffer, one row per start.
module charattr_row_fetch #(
  parameter int COLUMNS     = 80,
  parameter int ADDR_WIDTH  = 23,
  parameter int MAX_PENDING = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] row_address,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_request,
  output logic [ADDR_WIDTH-1:0] rd_address,
  input  logic                  rd_ack,
  input  logic                  rd_data_valid,
  input  logic [31:0]           rd_data,
  output logic [6:0]            wr_address,
  output logic                  wr_enable,
  output logic [31:0]           wr_data
);

  localparam int CW = $clog2(COLUMNS + 1);
  localparam int PW = $clog2(MAX_PENDING + 1);
  localparam logic [CW-1:0] COLS     = CW'(COLUMNS);
  localparam logic [CW-1:0] LAST_COL = CW'(COLUMNS - 1);
  localparam logic [PW-1:0] MAXP     = PW'(MAX_PENDING);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [CW-1:0]   req_count;
  logic [CW-1:0]   req_count_nx;
  logic [CW-1:0]   wr_count;
  logic [PW-1:0]   pending;
  logic [PW-1:0]   pending_nx;
  logic            request_nx;
  logic            accept;
  logic            start_ok;
  logic            wr_fire;
  logic            last_write;

  assign accept     = rd_request & rd_ack;
  assign start_ok   = (state == IDLE) & start;
  // Returns are only honoured while a row is active and something is owed,
  // so stray or post-reset data can never reach the row buffer.
  assign wr_fire    = rd_data_valid & (state != IDLE) & (pending != '0) & (wr_count < COLS);
  assign last_write = wr_fire & (wr_count == LAST_COL);

  always_comb begin
    req_count_nx = req_count;
    pending_nx   = pending;
    if (start_ok) begin
      req_count_nx = '0;
      pending_nx   = '0;
    end else begin
      if (accept) begin
        req_count_nx = req_count + CW'(1);
      end
      if (accept && !wr_fire) begin
        pending_nx = pending + PW'(1);
      end else if (!accept && wr_fire) begin
        pending_nx = pending - PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = FETCH;
        end
      end
      FETCH: begin
        if (last_write) begin
          state_nx = DONE;
        end else if (req_count_nx == COLS) begin
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (last_write) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_comb begin
    busy = (state == FETCH) || (state == DRAIN);
    done = (state == DONE);
  end

  // Looking at next-cycle pending lets a request go out as soon as a slot frees,
  // and keeps an unacked request asserted since pending can only fall meanwhile.
  always_comb begin
    request_nx = (state_nx == FETCH) && (req_count_nx < COLS) && (pending_nx < MAXP);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_request <= 1'b0;
      rd_address <= '0;
      req_count  <= '0;
      pending    <= '0;
      wr_count   <= '0;
      wr_enable  <= 1'b0;
      wr_address <= '0;
      wr_data    <= '0;
    end else begin
      rd_request <= request_nx;
      req_count  <= req_count_nx;
      pending    <= pending_nx;
      wr_enable  <= wr_fire;
      if (start_ok) begin
        rd_address <= row_address;
      end else if (accept) begin
        rd_address <= rd_address + ADDR_WIDTH'(1);
      end
      if (start_ok) begin
        wr_count <= '0;
      end else if (wr_fire) begin
        wr_count   <= wr_count + CW'(1);
        wr_address <= 7'(wr_count);
        wr_data    <= rd_data;
      end
    end
  end

endmodule
